// File: rtl/memory_bus_master_if.sv
// Request/response handshake bundle between upstream logic and the
// memory bus master.
interface memory_bus_master_if #(
    parameter int N = 8,
    parameter int M = 2
);
    logic         ReqValid;
    logic         ReqReady;
    logic         ReqWrite;
    logic [M-1:0] ReqAddr;
    logic [M-1:0] ReqLen;
    logic [N-1:0] WrData;
    logic         WrTake;
    logic         RespValid;
    logic         RespReady;
    logic [N-1:0] RespData;
    logic         Done;

    modport master (
        input  ReqValid, ReqWrite, ReqAddr, ReqLen, WrData, RespReady,
        output ReqReady, WrTake, RespValid, RespData, Done
    );

    modport slave (
        output ReqValid, ReqWrite, ReqAddr, ReqLen, WrData, RespReady,
        input  ReqReady, WrTake, RespValid, RespData, Done
    );
endinterface

// File: rtl/memory_bus_master.sv
// Burst master for a small register-file memory on a shared tri-state
// data bus: one ADDR cycle per beat, then a write or read/response phase.
module memory_bus_master #(
    parameter int N = 8,
    parameter int M = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    memory_bus_master_if.master bus,
    output logic [M-1:0]        Select,
    output logic                RW,
    inout  wire  [N-1:0]        DataBus
);
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RDATA,
        RESP
    } state_t;

    localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [M-1:0] addr_q, addr_d;
    logic [M-1:0] cnt_q, cnt_d;
    logic         write_q, write_d;
    logic [N-1:0] rdata_q, rdata_d;
    logic         done_q, done_d;
    logic         beat_end;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        beat_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ReqValid) begin
                    write_d = bus.ReqWrite;
                    addr_d  = bus.ReqAddr;
                    cnt_d   = bus.ReqLen;
                    state_d = ADDR;
                end
            end
            ADDR:  state_d = write_q ? WDATA : RDATA;
            WDATA: beat_end = 1'b1;
            RDATA: begin
                // Bus value is taken as-is, X/Z included.
                rdata_d = DataBus;
                state_d = RESP;
            end
            RESP:  beat_end = bus.RespReady;
            default: state_d = IDLE;
        endcase
        if (beat_end) begin
            if (cnt_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                cnt_d   = cnt_q - ONE;
                addr_d  = addr_q + ONE;
                state_d = ADDR;
            end
        end
    end

    assign bus.ReqReady  = (state_q == IDLE);
    assign bus.WrTake    = (state_q == WDATA);
    assign bus.RespValid = (state_q == RESP);
    assign bus.RespData  = rdata_q;
    assign bus.Done      = done_q;

    assign RW      = (state_q == WDATA);
    assign Select  = (state_q == IDLE) ? '0 : addr_q;
    assign DataBus = RW ? bus.WrData : 'z;
endmodule

// File: doc/memory_bus_master.md
MEMORY_BUS_MASTER -- requirements
Module: memory_bus_master

Interface
REQ-001 Parameter N, default 8: data word width; equals the attached memory's register width.
REQ-002 Parameter M, default 2: address width; the attached memory holds 2^M cells.
REQ-003 Clock  input  1  single clock; all state updates on posedge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on posedge Clock.
REQ-005 ReqValid  input  1  request present.
REQ-006 ReqReady  output  1  block accepts a request this cycle.
REQ-007 ReqWrite  input  1  1 = write burst, 0 = read burst.
REQ-008 ReqAddr  input  M  burst start address.
REQ-009 ReqLen  input  M  beats minus one (0 = 1 beat, 2^M-1 = 2^M beats).
REQ-010 WrData  input  N  write data for the current beat; consumed when WrTake=1.
REQ-011 WrTake  output  1  one-cycle pulse: WrData consumed; upstream presents the next beat's data next cycle.
REQ-012 RespValid  output  1  read data valid.
REQ-013 RespReady  input  1  consumer accepts RespData.
REQ-014 RespData  output  N  read data.
REQ-015 Done  output  1  one-cycle pulse after the last beat of any burst completes.
REQ-016 Select  output  M  memory cell select.
REQ-017 RW  output  1  memory mode: 0 = read, 1 = write.
REQ-018 DataBus  inout  N  shared data bus; the block drives it only while RW=1, otherwise high-Z.

Function
REQ-019 The FSM SHALL have the states IDLE, ADDR, WDATA, RDATA and RESP.
REQ-020 ReqReady SHALL be 1 only in IDLE; a request is accepted when ReqValid&ReqReady, which latches ReqWrite, ReqAddr and ReqLen, sets the beat counter to ReqLen and enters ADDR.
REQ-021 ADDR (1 cycle): Select=current address, RW=0, DataBus high-Z; next state is WDATA for a write, RDATA for a read.
REQ-022 WDATA (1 cycle): Select unchanged, RW=1, DataBus=WrData, WrTake=1; the memory writes on the closing edge.
REQ-023 RDATA (1 cycle): Select unchanged, RW=0; DataBus is captured into RespData on the closing edge, then the FSM enters RESP.
REQ-024 RESP: RespValid=1 and RespData held stable until RespValid&RespReady; the beat completes on that edge.
REQ-025 Beat completion: if the beat counter is 0, assert Done for one cycle and return to IDLE; otherwise decrement the counter, increment the address modulo 2^M (2^M-1 wraps to 0) and go to ADDR.
REQ-026 Select SHALL stay constant from ADDR through the end of its beat, so the memory's registered address always matches the beat.
REQ-027 Latency: a write beat takes 2 cycles; a read beat takes 3 cycles plus RespReady stall cycles; Done follows the last beat's completing edge.
REQ-028 In IDLE: Select=0, RW=0, DataBus high-Z, WrTake=0, RespValid=0, Done=0.
REQ-029 DataBus SHALL never be driven in a cycle where RW=0, including FSM transitions.
REQ-030 ReqValid asserted outside IDLE SHALL be ignored; the request is not lost, because upstream must hold it until ReqReady.
REQ-031 A Done pulse SHALL coincide with ReqReady=1; a new request accepted in that same cycle starts ADDR on the next cycle.
REQ-032 Read data SHALL be treated as unknown-safe: X/Z on DataBus is captured as-is, with no masking.

Reset
REQ-033 When Reset=1 at a posedge, regardless of state, the FSM SHALL go to IDLE with Select=0, RW=0, DataBus high-Z, RespData=0, RespValid=0, WrTake=0, Done=0, and the beat counter and address cleared.
REQ-034 A burst interrupted by Reset SHALL be abandoned; no Done is issued, and any write already completed at an earlier edge stays in memory.
REQ-035 Reset SHALL take priority over every simultaneous request or handshake.

Verification (N=8, M=2, bench includes the memory model)
REQ-036 Single write then read: write addr 2 data 0xA5, len 0, then read addr 2 len 0 -> WrTake pulses once, Done pulses twice, RespData=0xA5.
REQ-037 Wrap burst: write addr 3, len 3, data 0x11,0x22,0x33,0x44 -> cells 3,0,1,2 hold 0x11,0x22,0x33,0x44; a 4-beat read from 3 returns the same order.
REQ-038 Back-pressure: read burst len 1 with RespReady held 0 for 5 cycles -> RespValid and RespData stay stable; no Select change until accepted.
REQ-039 Bus ownership: every cycle check DataBus is driven by the block only when RW=1 -> no multiple-driver X on DataBus at any time.
REQ-040 Reset mid-burst: assert Reset during the WDATA of beat 2 of a 4-beat write -> IDLE next cycle with all outputs at reset values, no Done, and beat 1's data present in memory.
REQ-041 Back-to-back: ReqValid held high through the Done cycle with a second request -> the second request is accepted in the Done cycle and ADDR follows immediately.
